// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer.
// State encodings, register-field constants and the control bundle.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    MEM_WAIT   = 2'b10
  } state_t;

  typedef struct packed {
    logic en_pc;
    logic en_if;
    logic en_id;
    logic en_ex;
    logic en_mem;
    logic rst_if;
    logic rst_id;
    logic rst_ex;
  } ctrl_t;

  function automatic ctrl_t ctrl_flow();
    ctrl_t c;
    c = '0;
    c.en_pc  = 1'b1;
    c.en_if  = 1'b1;
    c.en_id  = 1'b1;
    c.en_ex  = 1'b1;
    c.en_mem = 1'b1;
    return c;
  endfunction

  function automatic ctrl_t ctrl_flush();
    ctrl_t c;
    c = '0;
    c.rst_if = 1'b1;
    c.rst_id = 1'b1;
    c.rst_ex = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard detector between the EX load and the ID consumer.
// Purely combinational.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = id_uses_rt & (ex_rt == id_rt);
  assign lu = ex_memread & (ex_rt != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: load-use bubble, branch flush, memory freeze.
// Define PIPE_PERF_CNT_EN to enable the stall/flush performance counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             reloj,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             enablePC,
  output logic             enableIF,
  output logic             enableID,
  output logic             enableEX,
  output logic             enableMEM,
  output logic             resetIF,
  output logic             resetID,
  output logic             resetEX,
  output logic             mem_timeout,
  output logic [1:0]       ctrl_state,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             lu, mw;
  logic             decide, chk_mw, chk_lu;
  ctrl_t            c;

  hazard_detect u_hazard (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .lu         (lu)
  );

  assign mw = mem_req & ~mem_ready;

  always_comb begin
    c       = ctrl_flow();
    state_d = RUN;
    cnt_d   = '0;
    to_d    = to_q;
    decide  = 1'b0;
    chk_mw  = 1'b0;
    chk_lu  = 1'b0;
    case (state_q)
      RUN: begin
        decide = 1'b1;
        chk_mw = 1'b1;
        chk_lu = 1'b1;
      end
      LOAD_STALL: begin
        decide = 1'b1;
        chk_mw = 1'b1;
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          c       = '0;
          state_d = MEM_WAIT;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
          if (cnt_d >= WAIT_MAX) to_d = 1'b1;
        end else begin
          decide = 1'b1;
          chk_lu = 1'b1;
        end
      end
      default: ;
    endcase
    // Priority: memory freeze, then branch flush, then load-use bubble
    if (decide) begin
      if (chk_mw && mw) begin
        c       = '0;
        state_d = MEM_WAIT;
        cnt_d   = CNT_ONE;
        if (cnt_d >= WAIT_MAX) to_d = 1'b1;
      end else if (ex_branch_taken) begin
        c.rst_if = 1'b1;
        c.rst_id = 1'b1;
      end else if (chk_lu && lu) begin
        c.en_pc  = 1'b0;
        c.en_if  = 1'b0;
        c.rst_id = 1'b1;
        state_d  = LOAD_STALL;
      end
    end
    if (reset) c = ctrl_flush();
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign enablePC    = c.en_pc;
  assign enableIF    = c.en_if;
  assign enableID    = c.en_id;
  assign enableEX    = c.en_ex;
  assign enableMEM   = c.en_mem;
  assign resetIF     = c.rst_if;
  assign resetID     = c.rst_id;
  assign resetEX     = c.rst_ex;
  assign mem_timeout = to_q;
  assign ctrl_state  = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  always_ff @(posedge reloj) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!c.en_pc) stall_q <= stall_q + 32'd1;
      if (c.rst_if) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl (MEM_WAIT_MAX = 3).
// Control bundle compared as {PC,IF,ID,EX,MEM,rIF,rID,rEX}.
module tb_pipeline_ctrl;

  logic        reloj = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_memread, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        enablePC, enableIF, enableID, enableEX, enableMEM;
  logic        resetIF, resetID, resetEX, mem_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cycles, flush_count;
  logic [7:0]  outs;

  int compared = 0;
  int mismatched = 0;

  localparam logic [7:0] O_RST   = 8'b00000_111;
  localparam logic [7:0] O_FLOW  = 8'b11111_000;
  localparam logic [7:0] O_LU    = 8'b00111_010;
  localparam logic [7:0] O_BR    = 8'b11111_110;
  localparam logic [7:0] O_FRZ   = 8'b00000_000;

  always #5 reloj = ~reloj;

  assign outs = {enablePC, enableIF, enableID, enableEX, enableMEM,
                 resetIF, resetID, resetEX};

  pipeline_ctrl #(.MEM_WAIT_MAX(3), .CNT_W(16)) dut (
    .reloj           (reloj),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .enablePC        (enablePC),
    .enableIF        (enableIF),
    .enableID        (enableID),
    .enableEX        (enableEX),
    .enableMEM       (enableMEM),
    .resetIF         (resetIF),
    .resetID         (resetID),
    .resetEX         (resetEX),
    .mem_timeout     (mem_timeout),
    .ctrl_state      (ctrl_state),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic idle();
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rt = 0; ex_memread = 0; ex_branch_taken = 0;
    mem_req = 0; mem_ready = 0;
  endtask

  // advance one cycle; inputs are driven on the falling edge
  task automatic next();
    @(negedge reloj);
  endtask

  task automatic chk_o(input string nm, input logic [7:0] exp);
    #1;
    compared++;
    if (outs !== exp) begin
      mismatched++;
      $display("FAIL %s outs got %b want %b", nm, outs, exp);
    end
  endtask

  task automatic chk_s(input string nm, input logic [1:0] exp);
    compared++;
    if (ctrl_state !== exp) begin
      mismatched++;
      $display("FAIL %s state got %b want %b", nm, ctrl_state, exp);
    end
  endtask

  task automatic chk_t(input string nm, input logic exp);
    compared++;
    if (mem_timeout !== exp) begin
      mismatched++;
      $display("FAIL %s timeout got %b want %b", nm, mem_timeout, exp);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    next(); chk_o("rst_c0", O_RST);
    next(); chk_o("rst_c1", O_RST);
    next(); reset = 0;
    chk_o("post_rst", O_FLOW);
    chk_s("post_rst", 2'b00);
    chk_t("post_rst", 1'b0);
  endtask

  task automatic test_load_use();
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    chk_o("lu_hit", O_LU);
    chk_s("lu_hit", 2'b00);
    next(); idle();
    chk_o("lu_stall", O_FLOW);
    chk_s("lu_stall", 2'b01);
    next();
    chk_o("lu_back", O_FLOW);
    chk_s("lu_back", 2'b00);
    // hazard held into the stall cycle is not re-evaluated
    ex_memread = 1; ex_rt = 5'd12; id_rt = 5'd12; id_uses_rt = 1;
    chk_o("lu_rt", O_LU);
    next();
    chk_o("lu_hold", O_FLOW);
    chk_s("lu_hold", 2'b01);
    next(); idle();
    chk_o("lu_done", O_FLOW);
    chk_s("lu_done", 2'b00);
  endtask

  task automatic test_no_stall();
    ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0;
    chk_o("r0", O_FLOW);
    next(); idle();
    chk_s("r0", 2'b00);
    ex_memread = 1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
    chk_o("rt_unused", O_FLOW);
    next(); idle();
    chk_s("rt_unused", 2'b00);
  endtask

  task automatic test_branch();
    ex_branch_taken = 1;
    ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8;
    chk_o("br_lu", O_BR);
    next(); idle();
    chk_s("br_lu", 2'b00);
    chk_o("br_after", O_FLOW);
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ready = 0;
    chk_o("mw_c0", O_FRZ);
    chk_s("mw_c0", 2'b00);
    next(); chk_o("mw_c1", O_FRZ); chk_s("mw_c1", 2'b10);
    chk_t("mw_c1", 1'b0);
    next(); chk_o("mw_c2", O_FRZ); chk_t("mw_c2", 1'b0);
    next(); chk_o("mw_c3", O_FRZ); chk_t("mw_c3", 1'b1);
    next(); mem_ready = 1;
    chk_o("mw_rdy", O_FLOW);
    chk_s("mw_rdy", 2'b10);
    next(); idle();
    chk_s("mw_run", 2'b00);
    chk_o("mw_run", O_FLOW);
    chk_t("mw_sticky", 1'b1);
  endtask

  task automatic test_back_to_back();
    mem_req = 1; mem_ready = 0;
    next(); chk_s("b2b_w", 2'b10);
    mem_ready = 1; ex_branch_taken = 1;
    ex_memread = 1; ex_rt = 5'd4; id_rs = 5'd4;
    chk_o("b2b_br", O_BR);
    next(); idle();
    chk_s("b2b_br", 2'b00);
    mem_req = 1; mem_ready = 0;
    next(); mem_ready = 1;
    ex_memread = 1; ex_rt = 5'd4; id_rs = 5'd4;
    chk_o("b2b_lu", O_LU);
    next(); idle();
    chk_s("b2b_lu", 2'b01);
    next();
  endtask

  task automatic test_reset_in_wait();
    mem_req = 1; mem_ready = 0;
    next(); chk_s("rw_wait", 2'b10);
    reset = 1; mem_req = 0;
    chk_o("rw_rst", O_RST);
    next(); reset = 0;
    chk_s("rw_state", 2'b00);
    chk_t("rw_to", 1'b0);
    compared++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      mismatched++;
      $display("FAIL rw_perf got %0d/%0d want 0/0", stall_cycles, flush_count);
    end
  endtask

  initial begin
    reset = 1;
    idle();
    next();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the per-stage enable and synchronous-reset (bubble) inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC enable. Resolves three conditions:
- load-use hazards, by inserting a one-cycle bubble;
- taken branches/jumps resolved in EX, by flushing the two younger instructions;
- multi-cycle data-memory accesses, by freezing the whole pipe until ready.

Parameters:
MEM_WAIT_MAX, 15, wait cycles in MEM_WAIT before mem_timeout sets (1..65535)
CNT_W, 16, width of internal wait counter

Ports:
reloj  in  1  clock, all state changes on posedge
reset  in  1  synchronous, active-high; sampled on posedge reloj only
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt as a source
ex_memread  in  1  instruction in EX is a load
ex_rt  in  5  load destination register in EX
ex_branch_taken  in  1  branch/jump taken, resolved in EX this cycle
mem_req  in  1  MEM stage performs a data-memory access this cycle
mem_ready  in  1  data memory completes the access this cycle
enablePC  out  1  PC load enable
enableIF  out  1  IF_ID enable
enableID  out  1  ID_EX enable
enableEX  out  1  EX_MEM enable
enableMEM  out  1  MEM_WB enable
resetIF  out  1  flush IF_ID (bubble)
resetID  out  1  flush ID_EX (bubble)
resetEX  out  1  flush EX_MEM
mem_timeout  out  1  sticky: wait exceeded MEM_WAIT_MAX
ctrl_state  out  2  current state, for debug

Behaviour:
- State register ctrl_state: RUN=00, LOAD_STALL=01, MEM_WAIT=10; 11 is unused and recovers to RUN next cycle with all enables at 1.
- All enable and reset outputs are combinational from state and inputs, so they act in the same cycle. State, counter and mem_timeout are registered.
- reset=1: all enables 0; resetIF, resetID, resetEX = 1. Next state RUN, counter 0, mem_timeout 0. Reset overrides any in-progress stall or wait.
- Hazard condition lu = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Memory-wait condition mw = mem_req & ~mem_ready.
- Default outputs (no condition active): all enables 1, all resets 0.
- RUN, priority mw > ex_branch_taken > lu:
  - mw: all enables 0, resets 0. Next MEM_WAIT, counter cleared to 1.
  - ex_branch_taken: enables 1, resetIF=1, resetID=1. Next RUN. A simultaneous lu is ignored because the ID instruction is killed.
  - lu: enablePC=0, enableIF=0, resetID=1, enableEX=1, enableMEM=1. Next LOAD_STALL.
  - none: default outputs, stay RUN.
- LOAD_STALL: lu is not re-evaluated. mw and ex_branch_taken are handled exactly as in RUN; otherwise default outputs, next RUN. Total load-use penalty is exactly 1 cycle.
- MEM_WAIT:
  - mem_ready=0: all enables 0, counter increments, saturating at 2^CNT_W-1. When counter reaches MEM_WAIT_MAX, mem_timeout is set and stays set until reset; the FSM keeps waiting.
  - mem_ready=1: evaluate as RUN with mw false, i.e. branch > lu > default. Next state follows the RUN rules; counter is cleared.
- resetEX is asserted only during reset.
- Latency: the decision is visible on the same cycle as the inputs; the pipeline registers capture on the following posedge.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments on every cycle with enablePC=0 outside reset.
  - flush_count increments on every cycle with resetIF=1 outside reset.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: both ports still exist and are tied to 0, with no counter logic.

Decomposition:
- Package pipeline_ctrl_pkg holds the state encodings RUN/LOAD_STALL/MEM_WAIT, the constant REG_ZERO=5'd0, and the register-field width 5.
- One sub-module, hazard_detect: purely combinational, computes lu from the ID/EX fields. pipeline_ctrl instantiates it once.

Test Plan:
1. reset=1 for 2 cycles, then 0 -> during reset all enables 0 and resetIF/ID/EX=1. After reset: ctrl_state=00, all enables 1, mem_timeout=0.
2. ex_memread=1, ex_rt=5'd8, id_rs=5'd8 for 1 cycle -> that cycle enablePC=0, enableIF=0, resetID=1. Next cycle ctrl_state=01 with default outputs; the cycle after, 00.
3. ex_memread=1, ex_rt=5'd0, id_rs=5'd0 -> no stall. Same with ex_rt=id_rt=5'd9 and id_uses_rt=0 -> no stall.
4. ex_branch_taken=1 together with a load-use match -> resetIF=1, resetID=1, enablePC=1, next state RUN (not LOAD_STALL).
5. mem_req=1, mem_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles, ctrl_state=10, then all enables 1 and RUN. With MEM_WAIT_MAX=3, mem_timeout rises after the 3rd wait cycle and stays set.
6. Assert reset while in MEM_WAIT -> next cycle ctrl_state=00, mem_timeout=0. With PIPE_PERF_CNT_EN defined, stall_cycles and flush_count read 0.
